// File: rtl/serial_add_controller.sv
// serial_add_controller
//   Performs one WIDTH-bit unsigned addition per request. The operands are
//   loaded in parallel and then shifted LSB-first through a 1-bit full adder
//   with a carry flop. The sum bits are collected in a shift register, and the
//   result is held until the consumer accepts it.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; returns the block to idle
//   in_valid   request strobe: data_a/data_b are valid
//   in_ready   block can accept a request (idle only)
//   data_a     operand A, captured on accept
//   data_b     operand B, captured on accept
//   out_valid  result valid (done only)
//   out_ready  consumer takes the result
//   out_sum    sum modulo 2^WIDTH; qualify with out_valid
//   carry_out  final carry (unsigned overflow); qualify with out_valid
//   busy       operation in flight or result pending
module serial_add_controller #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             carry_out,
  output logic             busy
);

  localparam int unsigned     CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   reg_a_q;
  logic [WIDTH-1:0]   reg_b_q;
  logic [WIDTH-1:0]   sum_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  // 1-bit full adder on the current LSBs.
  logic sum_bit;
  logic carry_d;

  always_comb begin
    sum_bit = reg_a_q[0] ^ reg_b_q[0] ^ carry_q;
    carry_d = (reg_a_q[0] & reg_b_q[0]) | (reg_a_q[0] & carry_q) | (reg_b_q[0] & carry_q);
  end

  // The handshake flags are registered alongside the state. As a result, no
  // output has a combinational path from in_valid or out_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      reg_a_q     <= '0;
      reg_b_q     <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            reg_a_q    <= data_a;
            reg_b_q    <= data_b;
            sum_q      <= '0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            state_q    <= StShift;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        StShift: begin
          reg_a_q <= reg_a_q >> 1;
          reg_b_q <= reg_b_q >> 1;
          sum_q   <= {sum_bit, sum_q[WIDTH-1:1]};
          carry_q <= carry_d;
          cnt_q   <= cnt_q + 1'b1;
          // The last shift happens on this same edge, which gives exactly
          // WIDTH shift cycles.
          if (cnt_q == LAST_CNT) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_sum   = sum_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_serial_add_controller.sv
// Bench for serial_add_controller. Unit 0 is WIDTH=4 and unit 1 is WIDTH=8.
// Expected results are queued when the control model accepts a request. A
// negedge monitor compares the control outputs every cycle and compares each
// presented result against the head of the matching queue.
module tb_serial_add_controller;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
  } exp_t;

  logic       clk = 1'b0;
  logic [1:0] rst;
  logic [1:0] in_valid;
  logic [1:0] out_ready;
  logic [1:0] in_ready;
  logic [1:0] out_valid;
  logic [1:0] busy;
  logic [1:0] cout;
  logic [7:0] da [2];
  logic [7:0] db [2];
  logic [3:0] sum4;
  logic [7:0] sum8;
  logic [7:0] exp_sum [2];
  logic       exp_cout [2];

  // Control model: 0 idle, 1 shift, 2 done.
  int   m_st [2]  = '{0, 0};
  int   m_cnt [2] = '{0, 0};
  exp_t q0 [$];
  exp_t q1 [$];

  int checks = 0;
  int errors = 0;
  bit end_req = 1'b0;
  bit end_ack = 1'b0;

  always #5 clk = ~clk;

  serial_add_controller #(.WIDTH(4)) u_dut4 (
    .clk      (clk),
    .reset    (rst[0]),
    .in_valid (in_valid[0]),
    .in_ready (in_ready[0]),
    .data_a   (da[0][3:0]),
    .data_b   (db[0][3:0]),
    .out_valid(out_valid[0]),
    .out_ready(out_ready[0]),
    .out_sum  (sum4),
    .carry_out(cout[0]),
    .busy     (busy[0])
  );

  serial_add_controller #(.WIDTH(8)) u_dut8 (
    .clk      (clk),
    .reset    (rst[1]),
    .in_valid (in_valid[1]),
    .in_ready (in_ready[1]),
    .data_a   (da[1]),
    .data_b   (db[1]),
    .out_valid(out_valid[1]),
    .out_ready(out_ready[1]),
    .out_sum  (sum8),
    .carry_out(cout[1]),
    .busy     (busy[1])
  );

  function automatic void check(input string nm, input int u, input logic [8:0] act,
                                input logic [8:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s unit%0d got %0h want %0h", nm, u, act, req);
    end
  endfunction

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      automatic int         w       = (u == 0) ? 4 : 8;
      automatic logic [7:0] act_sum = (u == 0) ? {4'h0, sum4} : sum8;
      automatic int         qn      = (u == 0) ? q0.size() : q1.size();
      automatic exp_t       e;
      check("ctrl", u, {6'd0, in_ready[u], out_valid[u], busy[u]},
            {6'd0, m_st[u] == 0, m_st[u] == 2, m_st[u] != 0});
      if (out_valid[u] === 1'b1) begin
        if (qn == 0) begin
          check("unexpected_result", u, {8'd0, out_valid[u]}, 9'd0);
        end else begin
          e = (u == 0) ? q0[0] : q1[0];
          check("sum", u, {1'b0, act_sum}, {1'b0, e.sum});
          check("cout", u, {8'd0, cout[u]}, {8'd0, e.cout});
          if (out_ready[u]) begin
            if (u == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
          end
        end
      end
      // Advance the model to the state after the next rising edge.
      if (rst[u]) begin
        m_st[u]  = 0;
        m_cnt[u] = 0;
        if (u == 0) q0.delete();
        else        q1.delete();
      end else begin
        case (m_st[u])
          0: if (in_valid[u]) begin
            e.sum  = exp_sum[u];
            e.cout = exp_cout[u];
            if (u == 0) q0.push_back(e);
            else        q1.push_back(e);
            m_st[u]  = 1;
            m_cnt[u] = 0;
          end
          1: if (m_cnt[u] == w - 1) m_st[u] = 2;
             else m_cnt[u]++;
          2: if (out_ready[u]) m_st[u] = 0;
          default: m_st[u] = 0;
        endcase
      end
    end
    if (end_req && !end_ack) begin
      check("drained", 0, 9'(q0.size() + q1.size()), 9'd0);
      end_ack = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int u, input bit rnd);
    int n = 0;
    while (m_st[u] != 0) begin
      if (rnd) out_ready[u] = ($urandom_range(0, 3) != 0);
      step();
      n++;
      if (n > 300) begin
        $display("FAIL wait_idle unit%0d model did not return to idle", u);
        $fatal(1, "stuck");
      end
    end
    if (rnd) out_ready[u] = 1'b1;
  endtask

  task automatic issue(input int u, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] es, input logic ec);
    da[u]       = a;
    db[u]       = b;
    exp_sum[u]  = es;
    exp_cout[u] = ec;
    in_valid[u] = 1'b1;
    step();
    in_valid[u] = 1'b0;
  endtask

  task automatic op(input int u, input logic [7:0] a, input logic [7:0] b,
                    input logic [7:0] es, input logic ec, input bit rnd);
    wait_idle(u, rnd);
    issue(u, a, b, es, ec);
  endtask

  initial begin
    rst       = 2'b11;
    in_valid  = 2'b00;
    out_ready = 2'b11;
    for (int u = 0; u < 2; u++) begin
      da[u]       = '0;
      db[u]       = '0;
      exp_sum[u]  = '0;
      exp_cout[u] = 1'b0;
    end
    step();
    step();
    rst = 2'b00;

    // Basic op, latency and single-cycle result.
    op(0, 8'd5, 8'd3, 8'd8, 1'b0, 1'b0);
    // Overflow and corner operands.
    op(0, 8'd9, 8'd8, 8'd1, 1'b1, 1'b0);
    op(0, 8'd15, 8'd15, 8'd14, 1'b1, 1'b0);
    op(0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);

    // Result held under backpressure; requests while busy are ignored.
    wait_idle(0, 1'b0);
    out_ready[0] = 1'b0;
    issue(0, 8'd6, 8'd7, 8'd13, 1'b0);
    for (int n = 0; n < 20 && m_st[0] != 2; n++) step();
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = i[0];
      da[0]       = 8'(i + 2);
      db[0]       = 8'(11 - i);
      step();
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    step();

    // Reset in the second shift cycle abandons the operation.
    wait_idle(0, 1'b0);
    issue(0, 8'd12, 8'd5, 8'd1, 1'b1);
    step();
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    op(0, 8'd1, 8'd2, 8'd3, 1'b0, 1'b0);

    // Back-to-back requests with in_valid held high.
    wait_idle(0, 1'b0);
    da[0]       = 8'd3;
    db[0]       = 8'd4;
    exp_sum[0]  = 8'd7;
    exp_cout[0] = 1'b0;
    in_valid[0] = 1'b1;
    step();
    da[0]       = 8'd10;
    db[0]       = 8'd10;
    exp_sum[0]  = 8'd4;
    exp_cout[0] = 1'b1;
    for (int n = 0; n < 20 && m_st[0] != 0; n++) step();
    step();
    in_valid[0] = 1'b0;

    // WIDTH=8 directed vectors.
    op(1, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    op(1, 8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0);
    op(1, 8'd200, 8'd100, 8'd44, 1'b1, 1'b0);
    op(1, 8'd5, 8'd3, 8'd8, 1'b0, 1'b0);

    // Random operands with random consumer backpressure.
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          automatic logic [7:0] a = 8'($urandom_range(0, 15));
          automatic logic [7:0] b = 8'($urandom_range(0, 15));
          automatic logic [8:0] s = {1'b0, a} + {1'b0, b};
          op(0, a, b, {4'h0, s[3:0]}, s[4], 1'b1);
        end
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          automatic logic [7:0] a = 8'($urandom_range(0, 255));
          automatic logic [7:0] b = 8'($urandom_range(0, 255));
          automatic logic [8:0] s = {1'b0, a} + {1'b0, b};
          op(1, a, b, s[7:0], s[8], 1'b1);
        end
      end
    join
    wait_idle(0, 1'b1);
    wait_idle(1, 1'b1);
    step();
    step();

    end_req = 1'b1;
    for (int n = 0; n < 5 && !end_ack; n++) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
